std_reset_sequencer: RTL
========================

# std_reset_sequencer

Produces the design's internal reset outputs from one asynchronous active-high reset source plus an optional synchronous soft-reset request. It asserts all outputs immediately. It releases them synchronously, in a fixed staggered order, each at its configured polarity. It sits at the top of each clock domain and drives the `rst` inputs of downstream blocks, whose `std_clock_info_t` reset polarity must match the corresponding output. `rst_done` tells control logic when the domain is fully out of reset.

## Interface
Parameters:
- `OUTPUTS`, 3: number of sequenced reset outputs, ≥1.
- `OUTPUT_POLARITY`, all `STD_RESET_POLARITY_HIGH`: `std_reset_polarity_t [OUTPUTS-1:0]`, active level per output.
- `SYNC_STAGES`, 2: release-synchronizer depth, ≥2.
- `HOLD_CYCLES`, 16: qualified cycles before output 0 releases, ≥1.
- `STAGE_GAP`, 4: cycles between consecutive output releases, ≥1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `soft_rst_req` in 1: synchronous level request to re-enter reset.
- `rst_out` out `OUTPUTS`: sequenced resets, each driven at its `OUTPUT_POLARITY`.
- `rst_done` out 1: high only in RUNNING.

## Operation
- All outputs are registered; no combinational path from inputs to `rst_out`, except the asynchronous assertion on `rst`.
- `rst` high asynchronously forces:
  - every `rst_out[k]` to its active level (1 for HIGH polarity, 0 for LOW);
  - `rst_done` = 0;
  - state = HOLD, counter = 0, output index = 0, synchronizer flops = 1.
- Release synchronizer: a `SYNC_STAGES` flop chain, async-set by `rst`, shifting in 0. Its output `sync_rst` deasserts synchronously.
- A qualified edge is a rising edge where the registered `sync_rst` = 0 and the sampled `soft_rst_req` = 0.
- State machine:
  - HOLD: counter increments on each qualified edge. On the `HOLD_CYCLES`-th qualified edge, release `rst_out[0]`. If `OUTPUTS`=1, go to RUNNING; otherwise reset the counter, set index = 1, go to RELEASE.
  - RELEASE: counter increments each edge. When it reaches `STAGE_GAP`, release `rst_out[index]` and clear the counter. If index = `OUTPUTS-1`, go to RUNNING; otherwise increment index.
  - RUNNING: all outputs inactive, `rst_done` = 1.
- `soft_rst_req` sampled high at any edge, in any state:
  - all outputs go active and `rst_done` = 0 after that edge;
  - state = HOLD, counter and index cleared.
  - Counting resumes only on qualified edges, so a held request keeps the block in HOLD.
- Outputs release strictly in index order and never re-assert except through `rst` or `soft_rst_req`.
- Counter width is `$clog2(max(HOLD_CYCLES,STAGE_GAP)+1)`; the counter saturates and never wraps.

## Timing
- Edge 1 is the first rising edge after `rst` falls; `sync_rst` goes low after edge `SYNC_STAGES`.
- After `rst` release:
  - `rst_out[0]` inactive after edge `SYNC_STAGES+HOLD_CYCLES`;
  - `rst_out[k]` inactive after edge `SYNC_STAGES+HOLD_CYCLES+k*STAGE_GAP`;
  - `rst_done` rises on the same edge as the last output release.
  - Defaults: edges 18, 22, 26; `rst_done` at 26.
- Soft reset: the request is high at edge e and first sampled low at edge f.
  - Outputs are active after edge e.
  - `rst_out[0]` releases after edge f+`HOLD_CYCLES`-1; later outputs follow at `STAGE_GAP` spacing.
- `rst` reasserted mid-sequence: outputs go active immediately, asynchronously; the sequence restarts from edge 1 after release.
- `rst` and `soft_rst_req` high together: `rst` dominates; the request is then treated as a normal soft reset once `rst` falls.
- Reset values: `rst_out[k]` = active level of `OUTPUT_POLARITY[k]`; `rst_done` = 0.

## Structure
- `std_pkg` gains:
  - `std_reset_seq_state_t` enum {`STD_RESET_SEQ_HOLD`, `STD_RESET_SEQ_RELEASE`, `STD_RESET_SEQ_RUNNING`};
  - function `std_reset_drive(polarity, active)`, returning the pin level. It is the inverse of `std_is_reset_active`.
- Sub-module `std_reset_synchronizer` (parameter `STAGES`): async-assert, sync-deassert chain. It is reusable standalone.
- The sequencer owns the FSM, counter, index and output registers.

## Test plan
- Defaults, `rst` pulse then release at time T → `rst_out` releases after edges 18/22/26 in order 0,1,2; `rst_done` rises at edge 26. Before that, `rst_out` = 3'b111.
- `OUTPUT_POLARITY`={LOW,HIGH,LOW} → reset value 3'b010; the final value after sequencing is 3'b101.
- `soft_rst_req` high for 5 cycles in RUNNING → all outputs active and `rst_done`=0 after the first sampling edge. `rst_out[0]` releases 15 edges after the first low sample.
- `rst` reasserted at edge 20 (mid-RELEASE, output 0 already released) → `rst_out[0]` active immediately without a clock edge. The full 18/22/26 sequence repeats after release.
- `rst` and `soft_rst_req` both high, `rst` drops while the request stays high 10 more cycles → no release during the request. `rst_out[0]` releases after edge f+15.
- `OUTPUTS`=1, `HOLD_CYCLES`=1 → `rst_out[0]` and `rst_done` both change after edge 3.

Source files
------------

// File: rtl/std_pkg.sv
// Shared types and helpers for clock/reset infrastructure blocks.
package std_pkg;

    typedef enum logic {
        STD_RESET_POLARITY_LOW  = 1'b0,
        STD_RESET_POLARITY_HIGH = 1'b1
    } std_reset_polarity_t;

    typedef struct packed {
        std_reset_polarity_t rst_polarity;
        logic [31:0]         freq_hz;
    } std_clock_info_t;

    typedef enum logic [1:0] {
        STD_RESET_SEQ_HOLD    = 2'd0,
        STD_RESET_SEQ_RELEASE = 2'd1,
        STD_RESET_SEQ_RUNNING = 2'd2
    } std_reset_seq_state_t;

    // Pin level -> "is reset asserted".
    function automatic logic std_is_reset_active(std_reset_polarity_t polarity, logic level);
        return (polarity == STD_RESET_POLARITY_HIGH) ? level : ~level;
    endfunction

    // "Reset asserted" -> pin level; inverse of std_is_reset_active.
    function automatic logic std_reset_drive(std_reset_polarity_t polarity, logic active);
        return (polarity == STD_RESET_POLARITY_HIGH) ? active : ~active;
    endfunction

    function automatic int std_max(int a, int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/std_reset_synchronizer.sv
// Asynchronous-assert, synchronous-deassert reset chain; usable standalone.
module std_reset_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    output logic sync_rst
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '1;
        end else begin
            chain <= {chain[STAGES-2:0], 1'b0};
        end
    end

    assign sync_rst = chain[STAGES-1];

endmodule

// File: rtl/std_reset_sequencer.sv
// Per-domain reset sequencer: immediate assertion, synchronous staggered release.
//   state   | meaning
//   HOLD    | all outputs active, counting qualified edges up to HOLD_CYCLES
//   RELEASE | releasing outputs 1..OUTPUTS-1, one every STAGE_GAP edges
//   RUNNING | all outputs inactive, rst_done high
module std_reset_sequencer
    import std_pkg::*;
#(
    parameter int                                OUTPUTS         = 3,
    parameter std_reset_polarity_t [OUTPUTS-1:0] OUTPUT_POLARITY = {OUTPUTS{STD_RESET_POLARITY_HIGH}},
    parameter int                                SYNC_STAGES     = 2,
    parameter int                                HOLD_CYCLES     = 16,
    parameter int                                STAGE_GAP       = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               soft_rst_req,
    output logic [OUTPUTS-1:0] rst_out,
    output logic               rst_done
);

    localparam int CNT_MAX = std_max(HOLD_CYCLES, STAGE_GAP);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = (OUTPUTS > 1) ? $clog2(OUTPUTS) : 1;

    function automatic logic [OUTPUTS-1:0] drive_all(logic active);
        logic [OUTPUTS-1:0] v;
        for (int k = 0; k < OUTPUTS; k++) begin
            v[k] = std_reset_drive(OUTPUT_POLARITY[k], active);
        end
        return v;
    endfunction

    localparam logic [OUTPUTS-1:0] ACTIVE_LVL   = drive_all(1'b1);
    localparam logic [OUTPUTS-1:0] INACTIVE_LVL = drive_all(1'b0);

    std_reset_seq_state_t state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n, cnt_inc;
    logic [IDX_W-1:0]     idx, idx_n;
    logic [OUTPUTS-1:0]   out_q, out_n;
    logic                 done_q, done_n;
    logic                 sync_rst;

    std_reset_synchronizer #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .sync_rst (sync_rst)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= STD_RESET_SEQ_HOLD;
            cnt    <= '0;
            idx    <= '0;
            out_q  <= ACTIVE_LVL;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            idx    <= idx_n;
            out_q  <= out_n;
            done_q <= done_n;
        end
    end

    // Saturating increment so a misconfigured compare can never wrap the counter.
    assign cnt_inc = (cnt == CNT_W'(CNT_MAX)) ? cnt : cnt + 1'b1;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        out_n   = out_q;

        if (soft_rst_req) begin
            state_n = STD_RESET_SEQ_HOLD;
            cnt_n   = '0;
            idx_n   = '0;
            out_n   = ACTIVE_LVL;
        end else begin
            case (state)
                STD_RESET_SEQ_HOLD: begin
                    if (!sync_rst) begin
                        if (cnt_inc == CNT_W'(HOLD_CYCLES)) begin
                            out_n[0] = INACTIVE_LVL[0];
                            cnt_n    = '0;
                            if (OUTPUTS == 1) begin
                                state_n = STD_RESET_SEQ_RUNNING;
                            end else begin
                                idx_n   = IDX_W'(1);
                                state_n = STD_RESET_SEQ_RELEASE;
                            end
                        end else begin
                            cnt_n = cnt_inc;
                        end
                    end
                end
                STD_RESET_SEQ_RELEASE: begin
                    if (cnt_inc == CNT_W'(STAGE_GAP)) begin
                        for (int k = 0; k < OUTPUTS; k++) begin
                            if (idx == IDX_W'(k)) begin
                                out_n[k] = INACTIVE_LVL[k];
                            end
                        end
                        cnt_n = '0;
                        if (idx == IDX_W'(OUTPUTS - 1)) begin
                            state_n = STD_RESET_SEQ_RUNNING;
                        end else begin
                            idx_n = idx + 1'b1;
                        end
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
                STD_RESET_SEQ_RUNNING: begin
                    out_n = INACTIVE_LVL;
                end
                default: begin
                    state_n = STD_RESET_SEQ_HOLD;
                    cnt_n   = '0;
                    idx_n   = '0;
                    out_n   = ACTIVE_LVL;
                end
            endcase
        end

        done_n = (state_n == STD_RESET_SEQ_RUNNING);
    end

    assign rst_out  = out_q;
    assign rst_done = done_q;

endmodule
